// File: rtl/sprite_animator.sv
// Sprite animator: a frame table of bitmaps stepped through by an enable-gated period divider.
// Ping-pong playback is built only when SPRITE_ANIM_PINGPONG_EN is defined; otherwise playback always loops.
module sprite_animator #(
    parameter int SPRITE_W   = 5,
    parameter int SPRITE_H   = 5,
    parameter int NUM_FRAMES = 4,
    parameter int DIV_W      = 24,
    localparam int PIX       = SPRITE_W * SPRITE_H,
    localparam int IW        = $clog2(NUM_FRAMES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] period,
    input  logic [IW-1:0]    last_frame,
    input  logic             mode,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_addr,
    input  logic [PIX-1:0]   wr_data,
    output logic [PIX-1:0]   shape,
    output logic [IW-1:0]    frame_idx,
    output logic             frame_adv,
    output logic             wrap
);

    localparam logic [IW-1:0]    ZERO_IDX   = {IW{1'b0}};
    localparam logic [IW-1:0]    ONE_IDX    = IW'(1'b1);
    localparam logic [IW-1:0]    MAX_IDX    = IW'(NUM_FRAMES - 1);
    localparam bit               FULL_RANGE = (NUM_FRAMES == (1 << IW));
    localparam logic [PIX-1:0]   ZERO_PIX   = {PIX{1'b0}};
    localparam logic [DIV_W-1:0] ZERO_CNT   = {DIV_W{1'b0}};

    logic [PIX-1:0]   table_q [NUM_FRAMES];
    logic [DIV_W-1:0] count_q, count_d;
    logic [IW-1:0]    frame_idx_q, frame_idx_d;
    logic [PIX-1:0]   shape_q, shape_d;
    logic             adv_q, adv_d;
    logic             wrap_q, wrap_d;

    logic [IW-1:0]    last_s;
    logic             wr_ok_s;
    logic             step_s;
    logic [IW-1:0]    next_idx_s;
    logic [IW-1:0]    shown_idx_s;

`ifdef SPRITE_ANIM_PINGPONG_EN
    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;
    dir_e dir_q, dir_d, dir_next_s;
`else
    logic unused_mode_s;
    assign unused_mode_s = mode;
`endif

    // With a power-of-two table every index is in range, so no clamp or address check is needed.
    generate
        if (FULL_RANGE) begin : g_full_range
            assign last_s  = last_frame;
            assign wr_ok_s = 1'b1;
        end else begin : g_part_range
            assign last_s  = (last_frame > MAX_IDX) ? MAX_IDX : last_frame;
            assign wr_ok_s = (wr_addr <= MAX_IDX);
        end
    endgenerate

    // Divider, next-frame selection and the registered output values.
    always_comb begin
        step_s      = enable && (count_q >= period);
        next_idx_s  = frame_idx_q;
        count_d     = count_q;
`ifdef SPRITE_ANIM_PINGPONG_EN
        dir_next_s  = DIR_UP;
        dir_d       = dir_q;
`endif

        if (enable) begin
            count_d = step_s ? ZERO_CNT : count_q + DIV_W'(1'b1);
        end else begin
            count_d = count_q;
        end

        if ((frame_idx_q > last_s) || (last_s == ZERO_IDX)) begin
            next_idx_s = ZERO_IDX;
`ifdef SPRITE_ANIM_PINGPONG_EN
        end else if (mode) begin
            // Index 0 always climbs, which also recovers a stale down direction.
            if (((dir_q == DIR_UP) && (frame_idx_q < last_s)) || (frame_idx_q == ZERO_IDX)) begin
                next_idx_s = frame_idx_q + ONE_IDX;
                dir_next_s = ((frame_idx_q + ONE_IDX) == last_s) ? DIR_DOWN : DIR_UP;
            end else begin
                next_idx_s = frame_idx_q - ONE_IDX;
                dir_next_s = (frame_idx_q == ONE_IDX) ? DIR_UP : DIR_DOWN;
            end
`endif
        end else begin
            next_idx_s = (frame_idx_q >= last_s) ? ZERO_IDX : frame_idx_q + ONE_IDX;
        end

`ifdef SPRITE_ANIM_PINGPONG_EN
        if (!enable) begin
            dir_d = dir_q;
        end else if (!mode) begin
            dir_d = DIR_UP;
        end else if (step_s) begin
            dir_d = dir_next_s;
        end else begin
            dir_d = dir_q;
        end
`endif

        shown_idx_s = step_s ? next_idx_s : frame_idx_q;
        frame_idx_d = shown_idx_s;
        adv_d       = step_s;
        wrap_d      = step_s && (next_idx_s == ZERO_IDX);

        // A same-edge write to the frame about to be shown bypasses the table.
        if (wr_en && wr_ok_s && (wr_addr == shown_idx_s)) begin
            shape_d = wr_data;
        end else begin
            shape_d = table_q[shown_idx_s];
        end
    end

    // Frame table storage, cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_FRAMES; i++) begin
                table_q[i] <= ZERO_PIX;
            end
        end else if (wr_en && wr_ok_s) begin
            table_q[wr_addr] <= wr_data;
        end else begin
            table_q <= table_q;
        end
    end

    // Divider, frame index, direction and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= ZERO_CNT;
            frame_idx_q <= ZERO_IDX;
            shape_q     <= ZERO_PIX;
            adv_q       <= 1'b0;
            wrap_q      <= 1'b0;
`ifdef SPRITE_ANIM_PINGPONG_EN
            dir_q       <= DIR_UP;
`endif
        end else begin
            count_q     <= count_d;
            frame_idx_q <= frame_idx_d;
            shape_q     <= shape_d;
            adv_q       <= adv_d;
            wrap_q      <= wrap_d;
`ifdef SPRITE_ANIM_PINGPONG_EN
            dir_q       <= dir_d;
`endif
        end
    end

    assign shape     = shape_q;
    assign frame_idx = frame_idx_q;
    assign frame_adv = adv_q;
    assign wrap      = wrap_q;

endmodule

// File: doc/sprite_animator.md
SPRITE_ANIMATOR -- requirements
Module: sprite_animator

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- SPRITE_W, 5, sprite bitmap width in pixels.
- SPRITE_H, 5, sprite bitmap height in pixels.
- NUM_FRAMES, 4, depth of frame table; minimum 2.
- DIV_W, 24, width of frame-period counter.
- Derived, not settable: PIX = SPRITE_W*SPRITE_H; IW = $clog2(NUM_FRAMES).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all logic on rising edge.
- reset, in, 1, synchronous, active-high reset.
- enable, in, 1, animation advance permitted.
- period, in, DIV_W, enabled cycles per frame minus 1.
- last_frame, in, IW, highest frame index in the sequence.
- mode, in, 1, 0 = loop, 1 = ping-pong.
- wr_en, in, 1, frame table write strobe.
- wr_addr, in, IW, frame table write index.
- wr_data, in, PIX, bitmap to write; bit r*SPRITE_W+c is row r, column c.
- shape, out, PIX, registered bitmap of the current frame.
- frame_idx, out, IW, registered current frame index.
- frame_adv, out, 1, one-cycle pulse when frame_idx changes or re-advances.
- wrap, out, 1, one-cycle pulse on an advance that lands on frame 0.

Function
REQ-003 Divider SHALL increment only on cycles with enable=1; advance occurs on an enabled cycle where count >= period, and count returns to 0 on that cycle.
REQ-004 With period=P held constant and enable=1, advances SHALL occur every P+1 cycles; P=0 SHALL advance every cycle.
REQ-005 enable=0 SHALL hold count, frame_idx, shape and direction, and SHALL force frame_adv=0 and wrap=0.
REQ-006 Effective last index L SHALL be min(last_frame, NUM_FRAMES-1).
REQ-007 In loop mode, an advance SHALL set next = (frame_idx >= L) ? 0 : frame_idx+1.
REQ-008 In ping-pong mode, direction SHALL be up or down: up steps +1 and turns down on reaching L; down steps -1 and turns up on reaching 0 (sequence for L=3: 0,1,2,3,2,1,0,1...).
REQ-009 Any advance with frame_idx > L SHALL go to frame 0 with direction up, in either mode.
REQ-010 L=0 SHALL keep frame_idx at 0, with frame_adv and wrap pulsing on every advance.
REQ-011 frame_adv and wrap SHALL be registered and SHALL assert in the same cycle that the new frame_idx and shape appear.
REQ-012 shape SHALL always equal the table entry at frame_idx, one register stage from the table; frame_idx and shape SHALL change in the same cycle.
REQ-013 A write SHALL take effect at the clock edge where wr_en=1.
REQ-014 If wr_addr equals the displayed index (or the index being advanced to, on the same edge), shape SHALL show wr_data from the next cycle; write wins over the old content.
REQ-015 wr_addr >= NUM_FRAMES SHALL be ignored.
REQ-016 A mode change SHALL take effect at the next advance; switching to loop SHALL clear direction to up.

Reset
REQ-017 reset=1 SHALL set count=0, frame_idx=0, direction up, shape all zeros, frame_adv=0, wrap=0, and every frame table entry to zero.
REQ-018 Reset SHALL override enable and wr_en in the same cycle, including mid-frame.
REQ-019 Outputs SHALL reach their reset values one edge after reset is asserted.

Configuration
REQ-020 Macro SPRITE_ANIM_PINGPONG_EN SHALL control ping-pong support.
- Defined: mode input and direction state SHALL be present as described.
- Undefined: mode SHALL be ignored, no direction state SHALL be built, and behaviour SHALL always be loop mode.

Verification
REQ-021 Load frames 0..3 with 25'h0000001..25'h0000004; period=2, L=3, mode=0, enable=1 -> frame_idx 0,1,2,3,0 at 3-cycle spacing; shape matches each frame; wrap only on the 3->0 step.
REQ-022 Ping-pong, L=3, period=0 -> frame_idx 1,2,3,2,1,0,1 on consecutive cycles; wrap on landing at 0; with the macro undefined -> 1,2,3,0.
REQ-023 enable low for 5 cycles mid-count -> count, frame_idx and shape frozen, no pulses; resume completes the remaining count.
REQ-024 Write 25'h1FFFFFF to displayed frame 2 -> shape equals 25'h1FFFFFF the next cycle without an advance; a write landing on the same edge as an advance into that frame -> new data shown.
REQ-025 At frame_idx=3, set last_frame=1 -> next advance goes to 0 with a wrap pulse; last_frame=0 -> idx stays 0, wrap on every advance.
REQ-026 Assert reset at count=1, frame 2 -> all outputs and table zero next cycle; the first advance occurs period+1 enabled cycles after release.
